wb_port_arbiter: RTL

- Owns the single register-file write port of the 16-bit core's writeback stage.
- Arbitrates between two producers: the ALU pipeline result and the memory load-return path.
- Uses a valid/ready handshake, memory-first priority and an ALU anti-starvation timer.
- Registers the winning write so the register file sees a clean, clocked write strobe.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_starve_timer.sv | 58 +++++
 rtl/wb_port_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
package wb_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned RADDR_W_DEF = 3;
    localparam int unsigned WAIT_CNT_W  = 4;

    typedef enum logic {
        MEM_PRI = 1'b0,
        ALU_PRI = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_starve_timer.sv
// Tracks how long a pending ALU result has been losing arbitration and
// flips priority to the ALU once it has waited MAX_WAIT unheld cycles.
module wb_starve_timer
    import wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic alu_valid,
    input  logic alu_granted,
    input  logic wb_hold,
    output logic alu_pri
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] CNT_SAT    = '1;

    arb_state_t            state, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;

    // State and wait counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= MEM_PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state: hold freezes everything, an ALU grant clears the wait,
    // and a losing ALU request counts up until priority is handed over.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (!wb_hold) begin
            if (alu_granted) begin
                state_next    = MEM_PRI;
                wait_cnt_next = '0;
            end else if (alu_valid) begin
                if (wait_cnt != CNT_SAT) begin
                    wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
                end
                if ((state == MEM_PRI) && (wait_cnt_next >= WAIT_LIMIT)) begin
                    state_next = ALU_PRI;
                end
            end else if (state == ALU_PRI) begin
                state_next    = MEM_PRI;
                wait_cnt_next = '0;
            end
        end
    end

    assign alu_pri = (state == ALU_PRI);

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants the single register-file write port to
// either the load-return path or the ALU and registers the winning write.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned RADDR_W      = RADDR_W_DEF,
    parameter int unsigned MAX_WAIT     = 3,
    parameter bit          ZERO_DISCARD = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wb_hold,
    input  logic               alu_valid,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               mem_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               alu_forced
);

    logic               alu_pri;
    logic               xfer;
    logic               do_write;
    logic [RADDR_W-1:0] win_rd;
    logic [DATA_W-1:0]  win_data;

    wb_starve_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_granted(alu_ready),
        .wb_hold    (wb_hold),
        .alu_pri    (alu_pri)
    );

    // Grant: the prioritised producer wins whenever it is valid; at most one ready.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset && !wb_hold) begin
            if (alu_pri) begin
                alu_ready = alu_valid;
                mem_ready = mem_valid & ~alu_valid;
            end else begin
                mem_ready = mem_valid;
                alu_ready = alu_valid & ~mem_valid;
            end
        end
    end

    // Winning write selection and register-0 discard.
    always_comb begin
        xfer     = alu_ready | mem_ready;
        win_rd   = alu_ready ? alu_rd   : mem_rd;
        win_data = alu_ready ? alu_data : mem_data;
        do_write = xfer && !(ZERO_DISCARD && (win_rd == '0));
    end

    // Output register: one-cycle write strobe, address/data hold otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            alu_forced <= 1'b0;
        end else begin
            rf_we      <= do_write;
            alu_forced <= alu_ready & alu_pri & mem_valid;
            if (do_write) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

endmodule
